// File: rtl/alu_pkg.sv
// alu_pkg: shared state encoding and ALU control codes for the shared-ALU sequencer.
package alu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [2:0] ALU_OR  = 3'b000;
    localparam logic [2:0] ALU_AND = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational two-way round-robin picker; on a tie the requester
// that did not win last time is chosen.
module rr_arb2 (
    input  logic [1:0] i_valid,
    input  logic       i_last_grant,
    output logic [1:0] o_grant,
    output logic       o_grant_idx
);

    assign o_grant_idx = i_valid[1] & (~i_valid[0] | ~i_last_grant);
    assign o_grant     = (|i_valid) ? (o_grant_idx ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: arbitrates two requesters onto one external ALU, holds the
// operands for EXEC_CYCLES, then returns the captured result with backpressure.
module alu_share_ctrl #(
    parameter int WIDTH       = 32,
    parameter int EXEC_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_ctrl,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_ctrl,
    output logic             req1_ready,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zero,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_out,
    output logic             rsp_zero,
    input  logic             rsp_ready
);

    import alu_pkg::*;

    localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

    state_t           r_state;
    state_t           w_next;
    logic [3:0]       r_cnt;
    logic             r_last;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic [2:0]       r_alu_ctrl;
    logic             r_rsp_id;
    logic [WIDTH-1:0] r_rsp_out;
    logic             r_rsp_zero;
    logic [1:0]       w_grant;
    logic             w_grant_idx;
    logic             w_idle;
    logic             w_accept;
    logic             w_capture;

    rr_arb2 u_arb (
        .i_valid      ({req1_valid, req0_valid}),
        .i_last_grant (r_last),
        .o_grant      (w_grant),
        .o_grant_idx  (w_grant_idx)
    );

    // Reset masks ready so no handshake can complete on a reset edge.
    assign w_idle    = (r_state == ST_IDLE) & ~reset;
    assign w_accept  = w_idle & (|w_grant);
    assign w_capture = (r_state == ST_EXEC) & (r_cnt == 4'd0);

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: w_next = w_accept ? ST_EXEC : ST_IDLE;
            ST_EXEC: w_next = w_capture ? ST_RESP : ST_EXEC;
            ST_RESP: w_next = rsp_ready ? ST_IDLE : ST_RESP;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        req0_ready = w_idle & w_grant[0];
        req1_ready = w_idle & w_grant[1];
        rsp_valid  = (r_state == ST_RESP);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt      <= 4'd0;
            r_last     <= 1'b1;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_ctrl <= 3'd0;
            r_rsp_id   <= 1'b0;
            r_rsp_out  <= '0;
            r_rsp_zero <= 1'b0;
        end else begin
            if (w_accept) begin
                r_alu_a    <= w_grant_idx ? req1_a : req0_a;
                r_alu_b    <= w_grant_idx ? req1_b : req0_b;
                r_alu_ctrl <= w_grant_idx ? req1_ctrl : req0_ctrl;
                r_rsp_id   <= w_grant_idx;
                r_last     <= w_grant_idx;
                r_cnt      <= CNT_LOAD;
            end else if (r_state == ST_EXEC && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_capture) begin
                r_rsp_out  <= alu_out;
                r_rsp_zero <= alu_zero;
            end
        end
    end

    assign alu_a    = r_alu_a;
    assign alu_b    = r_alu_b;
    assign alu_ctrl = r_alu_ctrl;
    assign rsp_id   = r_rsp_id;
    assign rsp_out  = r_rsp_out;
    assign rsp_zero = r_rsp_zero;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: drives two instances (EXEC_CYCLES 1 and 4) with directed
// tables, multi-cycle corner sequences and random traffic against a model.
module tb_alu_share_ctrl;

    import alu_pkg::*;

    typedef struct {
        logic        id;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  ctrl;
        logic [31:0] exp_out;
        logic        exp_zero;
        int          bp;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        vld [2][2];
    logic [31:0] opa [2][2];
    logic [31:0] opb [2][2];
    logic [2:0]  opc [2][2];
    logic        rdy [2][2];
    logic [31:0] aa  [2];
    logic [31:0] ab  [2];
    logic [2:0]  ac  [2];
    logic [31:0] ao  [2];
    logic        az  [2];
    logic        rv  [2];
    logic        rid [2];
    logic [31:0] ro  [2];
    logic        rz  [2];
    logic        rr  [2];

    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
        return (c == ALU_OR) ? (a | b) : (c == ALU_AND) ? (a & b) : (c == ALU_ADD) ? (a + b) : 32'd0;
    endfunction

    function automatic int exec_of(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        alu_share_ctrl #(.WIDTH(32), .EXEC_CYCLES(g == 0 ? 1 : 4)) u_dut (
            .clk        (clk),
            .reset      (rst),
            .req0_valid (vld[g][0]),
            .req0_a     (opa[g][0]),
            .req0_b     (opb[g][0]),
            .req0_ctrl  (opc[g][0]),
            .req0_ready (rdy[g][0]),
            .req1_valid (vld[g][1]),
            .req1_a     (opa[g][1]),
            .req1_b     (opb[g][1]),
            .req1_ctrl  (opc[g][1]),
            .req1_ready (rdy[g][1]),
            .alu_a      (aa[g]),
            .alu_b      (ab[g]),
            .alu_ctrl   (ac[g]),
            .alu_out    (ao[g]),
            .alu_zero   (az[g]),
            .rsp_valid  (rv[g]),
            .rsp_id     (rid[g]),
            .rsp_out    (ro[g]),
            .rsp_zero   (rz[g]),
            .rsp_ready  (rr[g])
        );
        assign ao[g] = alu_f(aa[g], ab[g], ac[g]);
        assign az[g] = (aa[g] == ab[g]);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_req(input int d, input int n, input logic v, input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
        vld[d][n] = v;
        opa[d][n] = a;
        opb[d][n] = b;
        opc[d][n] = c;
    endtask

    // Call at posedge+1 with inputs applied; returns at posedge+1 after the response handshake.
    task automatic run_op(input int d, input logic id, input logic [31:0] xa, input logic [31:0] xb,
                          input logic [2:0] xc, input logic [31:0] xo, input logic xz, input int bp, input string nm);
        int k = 0;
        int e = exec_of(d);
        rr[d] = (bp == 0);
        @(negedge clk);
        while (rdy[d][id] !== 1'b1 && k < 30) begin
            @(negedge clk);
            k++;
        end
        chk({nm, " grant"}, {30'd0, rdy[d][1], rdy[d][0]}, id ? 32'd2 : 32'd1);
        chk({nm, " grant_wait"}, k, 0);
        @(posedge clk); #1;
        for (int i = 0; i < e; i++) begin
            @(negedge clk);
            chk({nm, " exec_rsp_valid"}, {31'd0, rv[d]}, 0);
            chk({nm, " exec_ready"}, {30'd0, rdy[d][1], rdy[d][0]}, 0);
            chk({nm, " exec_alu_a"}, aa[d], xa);
            chk({nm, " exec_alu_b"}, ab[d], xb);
            chk({nm, " exec_alu_ctrl"}, {29'd0, ac[d]}, {29'd0, xc});
        end
        for (int i = 0; i <= bp; i++) begin
            @(negedge clk);
            chk({nm, " rsp_valid"}, {31'd0, rv[d]}, 1);
            chk({nm, " rsp_id"}, {31'd0, rid[d]}, {31'd0, id});
            chk({nm, " rsp_out"}, ro[d], xo);
            chk({nm, " rsp_zero"}, {31'd0, rz[d]}, {31'd0, xz});
            chk({nm, " resp_ready"}, {30'd0, rdy[d][1], rdy[d][0]}, 0);
            chk({nm, " resp_alu_a"}, aa[d], xa);
            rr[d] = (i == bp);
        end
        @(posedge clk); #1;
    endtask

    task automatic rand_test(input int d, input int cycles);
        int   e = exec_of(d);
        bit   busy = 0;
        bit   last = 1;
        int   acc = 0;
        logic [31:0] ea = 0, eb = 0;
        logic [2:0]  ec = 0;
        bit   eid = 0;
        bit   took [2] = '{0, 0};
        bit   gi, x0, x1, xv;
        @(posedge clk); #1;
        rst = 1;
        for (int n = 0; n < 2; n++) vld[d][n] = 0;
        @(posedge clk); #1;
        rst = 0;
        for (int c = 0; c < cycles; c++) begin
            for (int n = 0; n < 2; n++) begin
                if (took[n]) vld[d][n] = 0;
                if (!vld[d][n]) begin
                    if ($urandom_range(1, 0) == 1) begin
                        logic [31:0] ra = $urandom();
                        logic [31:0] rb = ($urandom_range(3, 0) == 0) ? ra : $urandom();
                        set_req(d, n, 1, ra, rb, 3'($urandom_range(2, 0)));
                    end
                end else if ($urandom_range(7, 0) == 0) begin
                    vld[d][n] = 0;
                end
            end
            rr[d] = ($urandom_range(9, 0) < 7);
            @(negedge clk);
            xv = busy && (c >= acc + e + 1);
            gi = (vld[d][0] && vld[d][1]) ? !last : vld[d][1];
            x0 = !busy && vld[d][0] && !gi;
            x1 = !busy && vld[d][1] && gi;
            chk("rand ready", {30'd0, rdy[d][1], rdy[d][0]}, {30'd0, x1, x0});
            chk("rand rsp_valid", {31'd0, rv[d]}, {31'd0, xv});
            if (xv) begin
                chk("rand rsp_id", {31'd0, rid[d]}, {31'd0, eid});
                chk("rand rsp_out", ro[d], alu_f(ea, eb, ec));
                chk("rand rsp_zero", {31'd0, rz[d]}, {31'd0, ea == eb});
            end
            chk("rand alu_a", aa[d], ea);
            chk("rand alu_b", ab[d], eb);
            chk("rand alu_ctrl", {29'd0, ac[d]}, {29'd0, ec});
            took[0] = x0;
            took[1] = x1;
            if (xv && rr[d]) begin
                busy = 0;
            end else if (x0 || x1) begin
                busy = 1;
                acc  = c;
                ea   = opa[d][gi];
                eb   = opb[d][gi];
                ec   = opc[d][gi];
                eid  = gi;
                last = gi;
            end
            @(posedge clk); #1;
        end
        for (int n = 0; n < 2; n++) vld[d][n] = 0;
        rr[d] = 1;
    endtask

    initial begin
        vec_t tbl[6];
        tbl[0] = '{1'b0, 32'd5,        32'd3,        ALU_ADD, 32'd8,        1'b0, 0};
        tbl[1] = '{1'b1, 32'hF0,       32'h3C,       ALU_AND, 32'h30,       1'b0, 0};
        tbl[2] = '{1'b1, 32'hFFFFFFFF, 32'd1,        ALU_ADD, 32'd0,        1'b0, 2};
        tbl[3] = '{1'b0, 32'h12345678, 32'h12345678, ALU_AND, 32'h12345678, 1'b1, 1};
        tbl[4] = '{1'b1, 32'd0,        32'd0,        ALU_OR,  32'd0,        1'b1, 0};
        tbl[5] = '{1'b0, 32'hF0,       32'h0F,       ALU_OR,  32'hFF,       1'b0, 0};

        rst = 1;
        for (int d = 0; d < 2; d++) begin
            rr[d] = 1;
            set_req(d, 0, 1, 32'd5, 32'd3, ALU_ADD);
            set_req(d, 1, 1, 32'hF0, 32'h3C, ALU_AND);
        end
        repeat (2) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                chk("reset ready", {30'd0, rdy[d][1], rdy[d][0]}, 0);
                chk("reset rsp_valid", {31'd0, rv[d]}, 0);
                chk("reset rsp_id", {31'd0, rid[d]}, 0);
                chk("reset rsp_out", ro[d], 0);
                chk("reset rsp_zero", {31'd0, rz[d]}, 0);
                chk("reset alu_a", aa[d], 0);
                chk("reset alu_b", ab[d], 0);
                chk("reset alu_ctrl", {29'd0, ac[d]}, 0);
            end
        end
        rst = 0;
        for (int d = 0; d < 2; d++) begin
            vld[d][0] = 0;
            vld[d][1] = 0;
        end

        for (int d = 0; d < 2; d++) begin
            @(posedge clk); #1;
            set_req(d, 0, 1, 32'd5, 32'd3, ALU_ADD);
            set_req(d, 1, 1, 32'hF0, 32'h3C, ALU_AND);
            for (int i = 0; i < 4; i++) begin
                if (i % 2 == 0) run_op(d, 1'b0, 32'd5, 32'd3, ALU_ADD, 32'd8, 1'b0, 0, "rr0");
                else            run_op(d, 1'b1, 32'hF0, 32'h3C, ALU_AND, 32'h30, 1'b0, 0, "rr1");
            end
            vld[d][0] = 0;
            vld[d][1] = 0;

            for (int t = 0; t < 6; t++) begin
                set_req(d, tbl[t].id, 1, tbl[t].a, tbl[t].b, tbl[t].ctrl);
                run_op(d, tbl[t].id, tbl[t].a, tbl[t].b, tbl[t].ctrl, tbl[t].exp_out, tbl[t].exp_zero, tbl[t].bp, "table");
                vld[d][tbl[t].id] = 0;
            end

            // last winner was requester 0, so requester 1 takes the tie and req0 waits through backpressure
            set_req(d, 0, 1, 32'd1, 32'd2, ALU_ADD);
            set_req(d, 1, 1, 32'd7, 32'd7, ALU_ADD);
            run_op(d, 1'b1, 32'd7, 32'd7, ALU_ADD, 32'd14, 1'b1, 5, "bp");
            vld[d][1] = 0;
            run_op(d, 1'b0, 32'd1, 32'd2, ALU_ADD, 32'd3, 1'b0, 0, "bp_next");
            vld[d][0] = 0;

            set_req(d, 0, 1, 32'd2, 32'd2, ALU_OR);
            @(negedge clk);
            chk("midrst grant", {30'd0, rdy[d][1], rdy[d][0]}, 1);
            @(posedge clk); #1;
            vld[d][0] = 0;
            if (exec_of(d) > 1) begin
                @(posedge clk); #1;
            end
            rst = 1;
            @(negedge clk);
            chk("midrst rsp_valid_in_reset", {31'd0, rv[d]}, 0);
            @(posedge clk); #1;
            rst = 0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                chk("midrst rsp_valid_after", {31'd0, rv[d]}, 0);
                chk("midrst alu_a_after", aa[d], 0);
            end
            @(posedge clk); #1;
            set_req(d, 0, 1, 32'd5, 32'd3, ALU_ADD);
            set_req(d, 1, 1, 32'hF0, 32'h3C, ALU_AND);
            run_op(d, 1'b0, 32'd5, 32'd3, ALU_ADD, 32'd8, 1'b0, 0, "midrst_next");
            vld[d][0] = 0;
            vld[d][1] = 0;
        end

        rand_test(0, 600);
        rand_test(1, 600);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
Sequencer and arbiter that shares one combinational ALU instance between two requesters, for example the fetch/branch unit and the execute stage. It accepts operand/control triples over valid/ready handshakes with round-robin arbitration and holds the operands stable on the ALU for a programmable settle time. It then captures the ALU result and zero flag into registers and returns them on a response channel with backpressure. The ALU sits outside this block; this block drives its a, b and ALUcontrol inputs and samples its out and zero outputs.

Parameters:
WIDTH, 32, datapath width of operands and result.
EXEC_CYCLES, 1, cycles the operands are held on the ALU before capture; legal range 1..15.

Ports:
clk  in  1  single clock, rising edge.
reset  in  1  synchronous, active-high reset.
req0_valid  in  1  requester 0 has an operation pending.
req0_a  in  WIDTH  operand a, requester 0.
req0_b  in  WIDTH  operand b, requester 0.
req0_ctrl  in  3  ALU control code, requester 0.
req0_ready  out  1  requester 0 operation accepted this cycle.
req1_valid, req1_a, req1_b, req1_ctrl, req1_ready: same as req0, for requester 1.
alu_a  out  WIDTH  to ALU input a.
alu_b  out  WIDTH  to ALU input b.
alu_ctrl  out  3  to ALU control input.
alu_out  in  WIDTH  from ALU result.
alu_zero  in  1  from ALU zero flag (a == b).
rsp_valid  out  1  response available.
rsp_id  out  1  requester that owns the response.
rsp_out  out  WIDTH  captured ALU result.
rsp_zero  out  1  captured ALU zero flag.
rsp_ready  in  1  consumer accepts the response.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, named reset.
- Reset values:
  - State is IDLE.
  - alu_a, alu_b, alu_ctrl, rsp_out, rsp_zero, rsp_id and rsp_valid are all 0.
  - The settle counter is 0.
  - last_grant is 1, so requester 0 wins the first tie.
- States are IDLE, EXEC and RESP.
- IDLE:
  - reqN_ready is combinational: it is high only in IDLE, and only for the granted requester.
  - If only one requester is valid, that requester is granted.
  - If both are valid, the requester that is not last_grant is granted.
  - On the edge with valid && ready:
    - req a, b and ctrl are latched into alu_a, alu_b and alu_ctrl.
    - rsp_id takes the granted index and last_grant is updated.
    - The counter loads EXEC_CYCLES-1.
    - State moves to EXEC.
  - If no requester is valid, the block stays in IDLE and all ready outputs are 0.
- EXEC:
  - All ready outputs are 0.
  - The counter decrements each cycle.
  - On the edge where the counter is 0, alu_out and alu_zero are captured into rsp_out and rsp_zero, and state moves to RESP.
- RESP:
  - rsp_valid is high, and rsp_id, rsp_out and rsp_zero are held stable.
  - On rsp_valid && rsp_ready, state moves to IDLE and rsp_valid falls.
  - New requests are not accepted in RESP, even when rsp_ready is high.
- Latency: for a handshake on the edge ending cycle T, the block is in EXEC during cycles T+1 to T+EXEC_CYCLES, and rsp_valid rises at cycle T+EXEC_CYCLES+1. Minimum issue interval is EXEC_CYCLES+2 cycles.
- alu_a, alu_b and alu_ctrl change only on a grant edge and otherwise hold their last values, including in IDLE and RESP.
- The ALU control code is passed through unmodified. Codes used in test: 000 OR, 001 AND, 010 ADD.
- Requesters must hold valid and operands stable until they see ready. Dropping valid before ready is legal and loses nothing.
- Reset in EXEC or RESP abandons the transaction: no response is produced and all registers return to their reset values.
- reset has priority over all handshakes in the same cycle.

Decomposition:
- Shared package alu_pkg:
  - State encoding for IDLE, EXEC and RESP.
  - ALU control constants ALU_OR=3'b000, ALU_AND=3'b001, ALU_ADD=3'b010.
- Sub-module rr_arb2: a combinational 2-way round-robin picker.
  - Inputs: valid[1:0], last_grant.
  - Outputs: grant[1:0] (one-hot or zero), grant_idx.
- The FSM, counter and registers live in alu_share_ctrl.

Test Plan:
1. Reset check: assert reset for 2 cycles with both requesters valid. Every output is 0 and both ready outputs stay 0.
2. Single ADD, EXEC_CYCLES=1, real ALU attached: req0 with a=5, b=3, ctrl=010. req0_ready is high in IDLE, rsp_valid rises at T+2 with rsp_out=8, rsp_zero=0, rsp_id=0.
3. Tie and round-robin: after reset, both requesters valid and held. Grants go 0, 1, 0, 1 in that order. req1 with a=0xF0, b=0x3C, ctrl=001 gives rsp_out=0x30, rsp_id=1.
4. Zero flag and backpressure: req1 with a=b=7, ctrl=010, and rsp_ready held low for 5 cycles. rsp_out=14, rsp_zero=1, and all rsp signals stay stable. req0_valid high throughout is not accepted until the cycle after the rsp handshake.
5. Settle counter, EXEC_CYCLES=4: rsp_valid rises exactly 5 cycles after the grant edge, and alu_a and alu_b stay constant throughout.
6. Reset mid-operation: assert reset in the second EXEC cycle. rsp_valid never rises, and the next request is granted normally, with requester 0 preferred on a tie.
